// File: rtl/seven_segment_display_scanner_pkg.sv
// rtl/seven_segment_display_scanner_pkg.sv - scan states and active-high hex glyphs {g,f,e,d,c,b,a}
package seven_segment_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = GLYPH_0;
         4'h1: g = GLYPH_1;
         4'h2: g = GLYPH_2;
         4'h3: g = GLYPH_3;
         4'h4: g = GLYPH_4;
         4'h5: g = GLYPH_5;
         4'h6: g = GLYPH_6;
         4'h7: g = GLYPH_7;
         4'h8: g = GLYPH_8;
         4'h9: g = GLYPH_9;
         4'hA: g = GLYPH_A;
         4'hB: g = GLYPH_B;
         4'hC: g = GLYPH_C;
         4'hD: g = GLYPH_D;
         4'hE: g = GLYPH_E;
         default: g = GLYPH_F;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seven_segment_display_scanner_if.sv
// rtl/seven_segment_display_scanner_if.sv - datapath-to-scanner bundle: digit data in, display pins out
interface seven_segment_display_scanner_if #(
   parameter int NUM_DIGITS = 2
);
   localparam int IW = $clog2(NUM_DIGITS);

   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic                    load;
   logic [NUM_DIGITS-1:0]   anode;
   logic [6:0]              seg;
   logic [IW-1:0]           digit_idx;
   logic                    frame_done;

   modport master (
      output digits, digit_en, load,
      input  anode, seg, digit_idx, frame_done
   );

   modport slave (
      input  digits, digit_en, load,
      output anode, seg, digit_idx, frame_done
   );
endinterface

// File: rtl/seven_segment_display_scanner_decoder.sv
// rtl/seven_segment_display_scanner_decoder.sv - combinational hex nibble to active-high glyph
module seven_segment_decoder
   import seven_segment_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);
   assign glyph = hex_to_seg(nibble);
endmodule

// File: rtl/seven_segment_display_scanner.sv
// rtl/seven_segment_display_scanner.sv - N-digit multiplexed scanner with blanking and frame-synchronous data
module seven_segment_display_scanner
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS       = 2,
   parameter int DWELL_CYCLES     = 240000,
   parameter int BLANK_CYCLES     = 2400,
   parameter bit ANODE_ACTIVE_LOW = 1'b1,
   parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
   input logic clk,
   input logic reset,
   seven_segment_display_scanner_if.slave bus
);
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
   localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};

   state_t                  state, nstate;
   logic [CW-1:0]           cnt, ncnt;
   logic [IW-1:0]           idx, nidx;
   logic                    fresh, boundary;
   logic [4*NUM_DIGITS-1:0] sh_digits, act_digits, nact_digits;
   logic [NUM_DIGITS-1:0]   sh_en, act_en, nact_en;
   logic [NUM_DIGITS-1:0]   onehot, anode_r;
   logic [3:0]              nib;
   logic [6:0]              glyph, seg_r;
   logic                    lit, fd_r;

   // Outputs are registered from the next-state view so pins and FSM state change on the same edge.
   always_comb begin
      nstate   = state;
      ncnt     = cnt + 1'b1;
      nidx     = idx;
      boundary = fresh;
      case (state)
         BLANK: begin
            if (BLANK_CYCLES == 0 || cnt == BLANK_LAST) begin
               nstate = SHOW;
               ncnt   = '0;
            end
         end
         SHOW: begin
            if (cnt == DWELL_LAST) begin
               ncnt   = '0;
               nstate = (BLANK_CYCLES == 0) ? SHOW : BLANK;
               if (idx == LAST_IDX) begin
                  nidx     = '0;
                  boundary = 1'b1;
               end else begin
                  nidx = idx + 1'b1;
               end
            end
         end
         default: ;
      endcase

      // A load coinciding with the frame boundary bypasses the shadow and lands in this frame.
      nact_digits = act_digits;
      nact_en     = act_en;
      if (boundary) begin
         nact_digits = bus.load ? bus.digits   : sh_digits;
         nact_en     = bus.load ? bus.digit_en : sh_en;
      end

      nib    = nact_digits[{nidx, 2'b00} +: 4];
      lit    = (nstate == SHOW) && nact_en[nidx];
      onehot = NUM_DIGITS'(1) << nidx;
   end

   seven_segment_decoder u_dec (
      .nibble (nib),
      .glyph  (glyph)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= BLANK;
         cnt        <= '0;
         idx        <= '0;
         fresh      <= 1'b1;
         sh_digits  <= '0;
         sh_en      <= '0;
         act_digits <= '0;
         act_en     <= '0;
         anode_r    <= ANODE_OFF;
         seg_r      <= SEG_OFF;
         fd_r       <= 1'b0;
      end else begin
         state      <= nstate;
         cnt        <= ncnt;
         idx        <= nidx;
         fresh      <= 1'b0;
         act_digits <= nact_digits;
         act_en     <= nact_en;
         if (bus.load) begin
            sh_digits <= bus.digits;
            sh_en     <= bus.digit_en;
         end
         anode_r <= lit ? (ANODE_ACTIVE_LOW ? ~onehot : onehot) : ANODE_OFF;
         seg_r   <= lit ? (SEG_ACTIVE_LOW ? ~glyph : glyph) : SEG_OFF;
         fd_r    <= (nstate == SHOW) && (nidx == LAST_IDX) && (ncnt == DWELL_LAST);
      end
   end

   assign bus.anode      = anode_r;
   assign bus.seg        = seg_r;
   assign bus.digit_idx  = idx;
   assign bus.frame_done = fd_r;
endmodule

// File: tb/tb_seven_segment_display_scanner.sv
// tb/tb_seven_segment_display_scanner.sv - scoreboard bench for the 4-digit scanner against a slot-arithmetic model
module tb_seven_segment_display_scanner;
   localparam int N     = 4;
   localparam int DW    = 10;
   localparam int BW    = 2;
   localparam int SLOT  = DW + BW;
   localparam int FRAME = N * SLOT;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   seven_segment_display_scanner_if #(.NUM_DIGITS(N)) bus ();

   seven_segment_display_scanner #(
      .NUM_DIGITS       (N),
      .DWELL_CYCLES     (DW),
      .BLANK_CYCLES     (BW),
      .ANODE_ACTIVE_LOW (1'b1),
      .SEG_ACTIVE_LOW   (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          e;
      logic [15:0] d;
      logic [3:0]  en;
   } ld_t;

   ld_t         loads[$];
   logic [13:0] sb[$];
   int          k     = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Expected pins after the kk-th edge since reset release: slot/phase from plain division,
   // frame data = newest load sampled no later than that frame's boundary edge.
   function automatic logic [13:0] expect_at(input int kk);
      int          slot  = (kk / SLOT) % N;
      int          phase = kk % SLOT;
      int          f     = kk / FRAME;
      int          bound = (f == 0) ? 1 : f * FRAME;
      logic [15:0] d     = '0;
      logic [3:0]  en    = '0;
      logic        show;
      logic [3:0]  nib;
      logic [3:0]  a;
      logic [6:0]  s;
      for (int i = loads.size() - 1; i >= 0; i--) begin
         if (loads[i].e <= bound) begin
            d  = loads[i].d;
            en = loads[i].en;
            break;
         end
      end
      show = (phase >= BW) && en[slot];
      nib  = d[slot*4 +: 4];
      a    = show ? ~(4'b0001 << slot) : 4'b1111;
      s    = show ? ~glyph[nib] : 7'h7F;
      return {a, s, 2'(slot), (slot == N - 1) && (phase == SLOT - 1)};
   endfunction

   task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s k=%0d: got %h required %h", name, k, got, exp);
      end
   endtask

   task automatic step(input logic rst, input logic ld, input logic [15:0] d, input logic [3:0] en);
      @(negedge clk);
      bus.load     = ld;
      bus.digits   = d;
      bus.digit_en = en;
      if (rst && !reset) begin
         reset = 1'b1;
         #1;
         check("async_reset", {bus.anode, bus.seg, 3'b000}, {4'hF, 7'h7F, 3'b000});
      end
      reset = rst;
      if (rst) begin
         k = 0;
         loads.delete();
         sb.push_back({4'hF, 7'h7F, 2'd0, 1'b0});
      end else begin
         k++;
         if (ld) loads.push_back('{k, d, en});
         sb.push_back(expect_at(k));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
   endtask

   task automatic to_phase(input int p);
      for (int i = 0; i < FRAME && ((k + 1) % FRAME) != p; i++)
         step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
   endtask

   always begin
      @(posedge clk);
      #1;
      if (sb.size() > 0)
         check("scan", {bus.anode, bus.seg, bus.digit_idx, bus.frame_done}, sb.pop_front());
   end

   initial begin
      bus.load     = 1'b0;
      bus.digits   = '0;
      bus.digit_en = '0;

      repeat (3) step(1'b1, 1'b1, 16'h1234, 4'hF);
      step(1'b0, 1'b1, 16'($urandom), 4'hF);
      idle(3 * FRAME - 1);

      to_phase(20);
      step(1'b0, 1'b1, 16'h3A7F, 4'hF);
      idle(2 * FRAME);

      to_phase(30);
      step(1'b0, 1'b1, 16'($urandom), 4'b0101);
      idle(2 * FRAME);

      to_phase(0);
      step(1'b0, 1'b1, 16'($urandom), 4'b1011);
      idle(FRAME);
      to_phase(1);
      step(1'b0, 1'b1, 16'($urandom), 4'hF);
      idle(2 * FRAME);

      repeat (600) step(1'b0, $urandom_range(0, 19) == 0, 16'($urandom), 4'($urandom));

      step(1'b0, 1'b1, 16'($urandom), 4'hF);
      idle(FRAME);
      to_phase(2 * SLOT + 5);
      repeat (3) step(1'b1, 1'b0, 16'($urandom), 4'($urandom));
      idle(FRAME + 5);
      step(1'b0, 1'b1, 16'($urandom), 4'($urandom));
      idle(2 * FRAME);

      @(posedge clk);
      #2;
      check("drain", 14'(sb.size()), 14'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
